// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, one transaction
// at a time, with LS priority bounded by a starvation counter and stale-fetch dropping.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              hold_n_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  state_t            state_next;
  logic              owner_ls;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drop_q;
  logic [3:0]        starve_cnt;

  logic any_req;
  logic if_wins;
  logic resp_done;
  logic deliver_if;

  assign any_req    = if_req_i | ls_req_i;
  assign if_wins    = if_req_i & (~ls_req_i | (starve_cnt == STARVE_LIM));
  assign resp_done  = (state == WAIT_RESP) & bus_rvalid_i;
  // A flush arriving together with the response must still drop the fetch.
  assign deliver_if = resp_done & ~owner_ls & ~drop_q & ~flush_i;

  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (any_req)      state_next = WAIT_GNT;
      WAIT_GNT:  if (bus_gnt_i)    state_next = WAIT_RESP;
      WAIT_RESP: if (bus_rvalid_i) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // The LS pulse releases the hold even though LS is still the recorded owner.
  always_comb begin
    bus_req_o = (state == WAIT_GNT);
    hold_n_o  = 1'b1;
    if (ls_req_i || (owner_ls && state != IDLE)) begin
      hold_n_o = 1'b0;
    end
    if (ls_rvalid_o) begin
      hold_n_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_ls   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_cnt <= '0;
      if_gnt_o   <= 1'b0;
      ls_gnt_o   <= 1'b0;
    end else begin
      if_gnt_o <= 1'b0;
      ls_gnt_o <= 1'b0;
      if (state == IDLE && any_req) begin
        if (if_wins) begin
          owner_ls   <= 1'b0;
          addr_q     <= if_addr_i;
          we_q       <= 1'b0;
          wdata_q    <= '0;
          starve_cnt <= '0;
          if_gnt_o   <= 1'b1;
        end else begin
          owner_ls <= 1'b1;
          addr_q   <= ls_addr_i;
          we_q     <= ls_we_i;
          wdata_q  <= ls_wdata_i;
          ls_gnt_o <= 1'b1;
          if (if_req_i && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      ls_rdata_o  <= '0;
    end else begin
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      if (resp_done && owner_ls) begin
        ls_rvalid_o <= 1'b1;
        if (!we_q) begin
          ls_rdata_o <= bus_rdata_i;
        end
      end
      if (deliver_if) begin
        if_rvalid_o <= 1'b1;
        if_rdata_o  <= bus_rdata_i;
      end
    end
  end

  // Drop flag lives only for the duration of one in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (state_next == IDLE) begin
      drop_q <= 1'b0;
    end else if (flush_i && !owner_ls && state != IDLE) begin
      drop_q <= 1'b1;
    end
  end

endmodule
